// File: rtl/rbz_spi_tx.sv
// rbz_spi_tx: SPI mode-0 master transmitter (csb/sclk/mosi) with a parallel frame
// interface. One frame of up to FRAME_W bits is sent MSB-first. Each SCLK half-period
// lasts CLK_DIV clock cycles.
// Build option: define RBZ_SPI_TX_DBUF_EN to add a one-entry holding register, which
// allows back-to-back frames separated by exactly CLK_DIV cycles of csb high.
module rbz_spi_tx #(
  parameter int FRAME_W = 96,
  parameter int CLK_DIV = 2,
  localparam int LEN_W = $clog2(FRAME_W + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [FRAME_W-1:0] i_data,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_csb,
  output logic               o_sclk,
  output logic               o_mosi
);

  // state   | meaning
  // IDLE    | no frame, csb high
  // SETUP   | csb low, first bit on mosi, sclk low for H cycles
  // SHIFT   | per bit: sclk high H cycles, then low H cycles (not for the last bit)
  // HOLD    | low phase after the last rising edge, mosi keeps the last bit
  // GAP     | csb high for H cycles; o_done in its first cycle
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  localparam logic [15:0] H_M1 = 16'(CLK_DIV - 1);

  state_t             r_state;
  state_t             w_next;
  logic [FRAME_W-1:0] r_shift;     // frame left-justified; MSB is the bit on mosi
  logic [LEN_W-1:0]   r_bits;      // rising edges still to produce
  logic [15:0]        r_div;       // half-period down-counter
  logic               r_phase;     // inside SHIFT: 1 = sclk high half
  logic               w_div_end;
  logic               w_last_bit;
  logic               w_accept;
  logic               w_load_in;   // start a frame straight from the inputs
  logic               w_load_hold; // start a frame from the holding register
  logic [LEN_W-1:0]   w_eff_len;
  logic [FRAME_W-1:0] w_aligned;

  assign w_div_end  = (r_div == 16'd0);
  assign w_last_bit = (r_bits == LEN_W'(1));
  assign w_accept   = i_start && o_ready;
  assign w_eff_len  = (i_len == '0 || i_len > LEN_W'(FRAME_W)) ? LEN_W'(FRAME_W) : i_len;
  // Move bit [len-1] to the top so shifting left always exposes the next bit.
  assign w_aligned  = i_data << (LEN_W'(FRAME_W) - w_eff_len);

`ifdef RBZ_SPI_TX_DBUF_EN
  logic [FRAME_W-1:0] r_hold_data;
  logic [LEN_W-1:0]   r_hold_len;
  logic               r_hold_vld;
  logic               w_gap_end;
  logic               w_push;

  assign w_gap_end   = (r_state == S_GAP) && w_div_end;
  // An accept on the last gap cycle with nothing held can go straight to SETUP.
  assign w_load_in   = w_accept && ((r_state == S_IDLE) || (w_gap_end && !r_hold_vld));
  assign w_load_hold = w_gap_end && r_hold_vld;
  assign w_push      = w_accept && !w_load_in;

  // Holding register: filled while busy, drained when the gap ends.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
      r_hold_len  <= '0;
    end else begin
      r_hold_vld <= w_push || (r_hold_vld && !w_load_hold);
      if (w_push) begin
        r_hold_data <= w_aligned;
        r_hold_len  <= w_eff_len;
      end
    end
  end
`else
  assign w_load_in   = w_accept;
  assign w_load_hold = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load_in) w_next = S_SETUP;
      S_SETUP: if (w_div_end) w_next = S_SHIFT;
      S_SHIFT: if (w_div_end && r_phase && w_last_bit) w_next = S_HOLD;
      S_HOLD:  if (w_div_end) w_next = S_GAP;
      S_GAP:   if (w_div_end) w_next = (w_load_in || w_load_hold) ? S_SETUP : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Divider, bit counter and shift register; counters reload at every phase boundary.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_shift <= '0;
      r_bits  <= '0;
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (w_load_in) begin
      r_shift <= w_aligned;
      r_bits  <= w_eff_len;
      r_div   <= H_M1;
      r_phase <= 1'b0;
`ifdef RBZ_SPI_TX_DBUF_EN
    end else if (w_load_hold) begin
      r_shift <= r_hold_data;
      r_bits  <= r_hold_len;
      r_div   <= H_M1;
      r_phase <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_SETUP: begin
          if (w_div_end) begin
            r_div   <= H_M1;
            r_phase <= 1'b1;
          end else r_div <= r_div - 16'd1;
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div <= H_M1;
            if (r_phase) begin
              r_bits  <= r_bits - LEN_W'(1);
              r_phase <= 1'b0;
              if (!w_last_bit) r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            end else r_phase <= 1'b1;
          end else r_div <= r_div - 16'd1;
        end
        S_HOLD: begin
          if (w_div_end) r_div <= H_M1;
          else           r_div <= r_div - 16'd1;
        end
        S_GAP: begin
          if (!w_div_end) r_div <= r_div - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; mosi is forced low whenever csb is high.
  always_comb begin
    o_busy = (r_state != S_IDLE);
    o_csb  = !((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD));
    o_sclk = (r_state == S_SHIFT) && r_phase;
    o_mosi = !o_csb && r_shift[FRAME_W-1];
    o_done = (r_state == S_GAP) && (r_div == H_M1);
`ifdef RBZ_SPI_TX_DBUF_EN
    o_ready = !r_hold_vld;
`else
    o_ready = (r_state == S_IDLE);
`endif
  end

endmodule

// File: tb/tb_rbz_spi_tx.sv
// Testbench for rbz_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=1) checked every
// cycle against a frame-level timing model, plus an SPI mode-0 slave that samples
// mosi on sclk rising edges and scores each finished frame.
module tb_rbz_spi_tx;
  localparam int FW = 96;
  localparam int LW = 7;

  logic          clk;
  logic          rst_n;
  logic [1:0]    start;
  logic [FW-1:0] data_i [2];
  logic [LW-1:0] len_i  [2];
  logic [1:0]    rdy, busy, done, csb, sclk, mosi;

  int vectors = 0;
  int errors  = 0;

  // model state per instance
  logic          m_in  [2];
  int            m_t   [2];
  int            m_gap [2];
  int            m_len [2];
  logic [FW-1:0] m_d   [2];
  int            q_n   [2];
  logic [FW-1:0] q_d   [2];
  int            q_l   [2];
  logic          exp_rdy [2];

  // slave-side observations per instance
  logic          s_pcsb [2], s_psclk [2], s_pmosi [2];
  int            s_low [2], s_high [2], s_ncap [2];
  logic [FW-1:0] s_cap [2];
  int            last_low [2], last_high [2], last_ncap [2], nfr [2];
  logic [FW-1:0] last_cap [2];

  rbz_spi_tx #(.FRAME_W(FW), .CLK_DIV(2)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start[0]), .i_data(data_i[0]),
    .i_len(len_i[0]), .o_ready(rdy[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_csb(csb[0]), .o_sclk(sclk[0]), .o_mosi(mosi[0]));

  rbz_spi_tx #(.FRAME_W(FW), .CLK_DIV(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start[1]), .i_data(data_i[1]),
    .i_len(len_i[1]), .o_ready(rdy[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_csb(csb[1]), .o_sclk(sclk[1]), .o_mosi(mosi[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hk(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [FW-1:0] lmask(input int l);
    logic [FW-1:0] one;
    one = '1;
    return (l >= FW) ? one : ((FW'(1) << l) - FW'(1));
  endfunction

  // mosi at cycle t of csb-low: first bit during setup, then the bit of the current
  // sclk period; it advances to the next bit at each falling edge except the last.
  function automatic logic exp_mosi(input logic [FW-1:0] d, input int l, input int t, input int h);
    int u, idx;
    if (t < h) return d[l-1];
    u   = t - h;
    idx = u / (2*h) + (((u % (2*h)) >= h) ? 1 : 0);
    if (idx > l - 1) idx = l - 1;
    return d[l-1-idx];
  endfunction

  task automatic chk(input string nm, input int k, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", nm, k, got, exp, $time);
    end
  endtask

  task automatic check_inst(input int k);
    int h;
    logic e_csb, e_sclk, e_mosi, e_done, e_busy;
    h = hk(k);
    if (!rst_n) begin
      m_in[k] = 1'b0; m_t[k] = 0; m_gap[k] = -1; q_n[k] = 0;
    end else begin
      if (exp_rdy[k] && start[k]) begin
        q_d[k] = data_i[k];
        q_l[k] = (len_i[k] == 0 || int'(len_i[k]) > FW) ? FW : int'(len_i[k]);
        q_n[k] = 1;
      end
      if (m_in[k]) begin
        m_t[k]++;
        if (m_t[k] == h + 2*h*m_len[k]) begin m_in[k] = 1'b0; m_gap[k] = 0; end
      end else if (m_gap[k] >= 0) begin
        m_gap[k]++;
        if (m_gap[k] == h) m_gap[k] = -1;
      end
      if (!m_in[k] && m_gap[k] < 0 && q_n[k] > 0) begin
        m_in[k] = 1'b1; m_t[k] = 0; m_d[k] = q_d[k]; m_len[k] = q_l[k]; q_n[k] = 0;
      end
    end
    e_csb  = !m_in[k];
    e_sclk = 1'b0;
    e_mosi = 1'b0;
    if (m_in[k]) begin
      e_sclk = (m_t[k] >= h) && (((m_t[k] - h) % (2*h)) < h);
      e_mosi = exp_mosi(m_d[k], m_len[k], m_t[k], h);
    end
    e_done = (m_gap[k] == 0);
    e_busy = m_in[k] || (m_gap[k] >= 0);
`ifdef RBZ_SPI_TX_DBUF_EN
    exp_rdy[k] = (q_n[k] == 0);
`else
    exp_rdy[k] = !e_busy;
`endif
    chk("csb",   k, FW'(csb[k]),  FW'(e_csb));
    chk("sclk",  k, FW'(sclk[k]), FW'(e_sclk));
    chk("mosi",  k, FW'(mosi[k]), FW'(e_mosi));
    chk("done",  k, FW'(done[k]), FW'(e_done));
    chk("busy",  k, FW'(busy[k]), FW'(e_busy));
    chk("ready", k, FW'(rdy[k]),  FW'(exp_rdy[k]));

    if (!rst_n) begin
      s_pcsb[k] = 1'b1; s_psclk[k] = 1'b0; s_pmosi[k] = 1'b0; s_high[k] = 0; s_low[k] = 0;
    end else begin
      if (!csb[k]) begin
        if (s_pcsb[k]) begin
          last_high[k] = s_high[k]; s_low[k] = 0; s_cap[k] = '0; s_ncap[k] = 0;
        end
        s_low[k]++;
        if (sclk[k] && !s_psclk[k]) begin
          s_cap[k] = {s_cap[k][FW-2:0], mosi[k]};
          s_ncap[k]++;
        end
        if (sclk[k] && s_psclk[k]) chk("mosi_stable_high", k, FW'(mosi[k]), FW'(s_pmosi[k]));
      end else begin
        if (!s_pcsb[k]) begin
          last_low[k] = s_low[k]; last_cap[k] = s_cap[k]; last_ncap[k] = s_ncap[k];
          nfr[k]++;
          s_high[k] = 0;
          chk("frame_bits", k, s_cap[k] & lmask(m_len[k]), m_d[k] & lmask(m_len[k]));
          chk("frame_edges", k, FW'(s_ncap[k]), FW'(m_len[k]));
        end
        s_high[k]++;
      end
      s_pcsb[k] = csb[k]; s_psclk[k] = sclk[k]; s_pmosi[k] = mosi[k];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
  endtask

  task automatic send(input int k, input logic [FW-1:0] d, input int l);
    start[k] = 1'b1; data_i[k] = d; len_i[k] = LW'(l);
    tick();
    start[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((m_in[k] || m_gap[k] >= 0 || q_n[k] != 0) && n < 3000) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL idle_timeout inst%0d waited %0d cycles, limit 3000", k, n);
    end
  endtask

  initial begin
    int base;
    logic [FW-1:0] first_d, second_d;
    for (int k = 0; k < 2; k++) begin
      m_in[k] = 1'b0; m_t[k] = 0; m_gap[k] = -1; m_len[k] = 1; m_d[k] = '0;
      q_n[k] = 0; q_d[k] = '0; q_l[k] = 0; exp_rdy[k] = 1'b1;
      s_pcsb[k] = 1'b1; s_psclk[k] = 1'b0; s_pmosi[k] = 1'b0;
      s_low[k] = 0; s_high[k] = 0; s_ncap[k] = 0; s_cap[k] = '0;
      last_low[k] = 0; last_high[k] = 0; last_ncap[k] = 0; nfr[k] = 0; last_cap[k] = '0;
      data_i[k] = '0; len_i[k] = '0;
    end
    rst_n = 1'b0; start = 2'b00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // A5, 8 bits, H=2
    send(0, FW'(8'hA5), 8);
    wait_idle(0);
    chk("t1_low_cycles", 0, FW'(last_low[0]), FW'(34));
    chk("t1_bits", 0, last_cap[0] & lmask(8), FW'(8'hA5));
    chk("t1_edges", 0, FW'(last_ncap[0]), FW'(8));

    // len=0 means a full 96-bit frame
    send(0, 96'h0123_4567_89AB_CDEF_0123_4567, 0);
    wait_idle(0);
    chk("t2_low_cycles", 0, FW'(last_low[0]), FW'(386));
    chk("t2_bits", 0, last_cap[0], 96'h0123_4567_89AB_CDEF_0123_4567);

    // reset during the 41st bit of a 96-bit frame: no done, then a clean frame
    base = nfr[0];
    send(0, {$urandom, $urandom, $urandom}, 96);
    repeat (162) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t3_no_frame_end", 0, FW'(nfr[0]), FW'(base));
    send(0, FW'(12'h5C3), 12);
    wait_idle(0);
    chk("t3_bits_after_reset", 0, last_cap[0] & lmask(12), FW'(12'h5C3));

    // start held high with changing data during a frame
    base = nfr[0];
    start[0] = 1'b1; len_i[0] = LW'(8);
    first_d = '0; second_d = '0;
    for (int i = 0; i < 20; i++) begin
      data_i[0] = FW'($urandom_range(0, 255));
      if (i == 0) first_d = data_i[0];
      if (i == 1) second_d = data_i[0];
      tick();
    end
    start[0] = 1'b0;
    wait_idle(0);
`ifdef RBZ_SPI_TX_DBUF_EN
    chk("t4_frames", 0, FW'(nfr[0] - base), FW'(2));
    chk("t4_bits", 0, last_cap[0] & lmask(8), second_d);
`else
    chk("t4_frames", 0, FW'(nfr[0] - base), FW'(1));
    chk("t4_bits", 0, last_cap[0] & lmask(8), first_d);
`endif

    // H=1 instance: csb low 1 + 2*len
    send(1, FW'(5'h13), 5);
    wait_idle(1);
    chk("t4_h1_low_cycles", 1, FW'(last_low[1]), FW'(11));
    chk("t4_h1_bits", 1, last_cap[1] & lmask(5), FW'(5'h13));

    // two 16-bit frames
    base = nfr[0];
`ifdef RBZ_SPI_TX_DBUF_EN
    send(0, FW'(16'hBEEF), 16);
    send(0, FW'(16'h1234), 16);
    wait_idle(0);
    chk("t5_gap_cycles", 0, FW'(last_high[0]), FW'(2));
`else
    send(0, FW'(16'hBEEF), 16);
    wait_idle(0);
    send(0, FW'(16'h1234), 16);
    wait_idle(0);
`endif
    chk("t5_frames", 0, FW'(nfr[0] - base), FW'(2));
    chk("t5_low_cycles", 0, FW'(last_low[0]), FW'(66));
    chk("t5_bits", 0, last_cap[0] & lmask(16), FW'(16'h1234));

    // random traffic on both instances with rare resets
    for (int i = 0; i < 8000; i++) begin
      for (int k = 0; k < 2; k++) begin
        start[k]  = ($urandom_range(0, 7) == 0);
        data_i[k] = {$urandom, $urandom, $urandom};
        len_i[k]  = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 127))
                                                : LW'($urandom_range(1, 12));
      end
      rst_n = ($urandom_range(0, 2999) != 0);
      tick();
    end
    start = 2'b00;
    rst_n = 1'b1;
    wait_idle(0);
    wait_idle(1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
